// File: rtl/col2im_accum_if.sv
// Stream bundle for col2im_accum: patch-element input stream and pixel output stream.
// The design takes the slave modport; the producer/consumer side takes master.
interface col2im_accum_if #(
  parameter int DW = 8,
  parameter int AW = 12
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_data;
  logic          m_last;
  logic          frame_done;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, frame_done
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, frame_done
  );
endinterface

// File: rtl/col2im_accum.sv
// 3x3 col2im: scatter-adds an im2col patch stream into an IMG_W x IMG_W map,
// then streams the map out in raster order, zeroing it as it drains.
module col2im_accum #(
  parameter int IMG_W = 28,
  parameter int K     = 3,
  parameter int DW    = 8,
  parameter int AW    = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  col2im_accum_if.slave  io
);
  localparam int OW   = IMG_W - K + 1;
  localparam int NPIX = IMG_W * IMG_W;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int OWW  = (OW > 1) ? $clog2(OW) : 1;
  localparam int PW   = $clog2(NPIX);

  localparam logic [KW-1:0]  K_LAST   = KW'(K - 1);
  localparam logic [OWW-1:0] OW_LAST  = OWW'(OW - 1);
  localparam logic [PW-1:0]  PIX_LAST = PW'(NPIX - 1);

  typedef enum logic [1:0] {INIT, ACCUM, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  n_q, n_d, m_q, m_d;
  logic [OWW-1:0] l_q, l_d, k_q, k_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic           frame_done_q, frame_done_d;

  logic [AW-1:0]  acc_q [NPIX];
  logic           acc_we;
  logic [PW-1:0]  acc_widx;
  logic [AW-1:0]  acc_wdata;
  logic [PW-1:0]  idx;

  // Source pixel of the current patch element: (k+m, l+n).
  assign idx = (PW'(k_q) + PW'(m_q)) * PW'(IMG_W) + PW'(l_q) + PW'(n_q);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    m_d          = m_q;
    l_d          = l_q;
    k_d          = k_q;
    pix_d        = pix_q;
    frame_done_d = 1'b0;
    acc_we       = 1'b0;
    acc_widx     = pix_q;
    acc_wdata    = '0;
    unique case (state_q)
      INIT: begin
        acc_we = 1'b1;
        if (pix_q == PIX_LAST) begin
          pix_d   = '0;
          state_d = ACCUM;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      ACCUM: begin
        if (io.s_valid) begin
          acc_we    = 1'b1;
          acc_widx  = idx;
          acc_wdata = acc_q[idx] + AW'(io.s_data);
          if (n_q != K_LAST) n_d = n_q + 1'b1;
          else begin
            n_d = '0;
            if (m_q != K_LAST) m_d = m_q + 1'b1;
            else begin
              m_d = '0;
              if (l_q != OW_LAST) l_d = l_q + 1'b1;
              else begin
                l_d = '0;
                if (k_q != OW_LAST) k_d = k_q + 1'b1;
                else begin
                  k_d     = '0;
                  state_d = DRAIN;
                end
              end
            end
          end
        end
      end
      DRAIN: begin
        if (io.m_ready) begin
          acc_we = 1'b1;
          if (pix_q == PIX_LAST) begin
            pix_d        = '0;
            state_d      = ACCUM;
            frame_done_d = 1'b1;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      n_q          <= '0;
      m_q          <= '0;
      l_q          <= '0;
      k_q          <= '0;
      pix_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      m_q          <= m_d;
      l_q          <= l_d;
      k_q          <= k_d;
      pix_q        <= pix_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Map storage is cleared by the INIT pass, so it carries no reset.
  always_ff @(posedge clk) begin
    if (acc_we) acc_q[acc_widx] <= acc_wdata;
  end

  assign io.s_ready    = (state_q == ACCUM);
  assign io.m_valid    = (state_q == DRAIN);
  assign io.m_data     = (state_q == DRAIN) ? acc_q[pix_q] : '0;
  assign io.m_last     = (state_q == DRAIN) && (pix_q == PIX_LAST);
  assign io.frame_done = frame_done_q;
endmodule

// File: tb/tb_col2im_accum.sv
// Directed bench for col2im_accum: hand-computed pixel tables per input pattern,
// plus stall, back-to-back and mid-frame reset sequences.
module tb_col2im_accum;
  localparam int IMG_W = 28;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int OW    = IMG_W - K + 1;
  localparam int NPIX  = IMG_W * IMG_W;
  localparam int NELEM = OW * OW * K * K;

  // Patterns: 0 all-ones, 1 all-255, 2 element index e, 3 all-twos
  typedef struct {
    int    pat;
    int    r;
    int    c;
    int    exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  col2im_accum_if #(.DW(DW), .AW(AW)) bus ();

  col2im_accum #(.IMG_W(IMG_W), .K(K), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int   nchk = 0;
  int   nerr = 0;
  int   fd_cnt = 0;
  int   got [NPIX];
  int   ref_map [NPIX];
  vec_t vecs [$];

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int elem_val(input int pat, input int i);
    case (pat)
      0:       return 1;
      1:       return 255;
      2:       return i % (K * K);
      default: return 2;
    endcase
  endfunction

  // Drive nelem elements; decisions are made at the negedge, handshake at the next posedge.
  task automatic feed(input int pat, input bit gaps, input int nelem);
    int cnt = 0;
    int cyc = 0;
    while (cnt < nelem && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_data  = DW'(elem_val(pat, cnt));
      if (bus.s_valid && bus.s_ready) cnt++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("feed_count", cnt, nelem);
    if (nelem == NELEM) begin
      chk("accum_exit_s_ready", int'(bus.s_ready), 0);
      chk("accum_exit_m_valid", int'(bus.m_valid), 1);
    end
  endtask

  task automatic drain(input bit stalls);
    int            cnt = 0;
    int            cyc = 0;
    int            unstable = 0;
    int            lastbad = 0;
    bit            pend = 0;
    logic [AW-1:0] prev = '0;
    while (cnt < NPIX && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.m_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_valid) begin
        if (pend && bus.m_data !== prev) unstable++;
        if (bus.m_last !== (cnt == NPIX - 1)) lastbad++;
        if (bus.m_ready) begin
          got[cnt] = int'(bus.m_data);
          cnt++;
          pend = 0;
        end else begin
          pend = 1;
          prev = bus.m_data;
        end
      end
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("drain_count", cnt, NPIX);
    chk("stall_stable_errs", unstable, 0);
    chk("m_last_errs", lastbad, 0);
    chk("frame_done_pulse", int'(bus.frame_done), 1);
    chk("frame_done_s_ready", int'(bus.s_ready), 1);
  endtask

  task automatic check_table(input int pat);
    foreach (vecs[i]) if (vecs[i].pat == pat)
      chk(vecs[i].name, got[vecs[i].r * IMG_W + vecs[i].c], vecs[i].exp);
  endtask

  task automatic frame(input int pat, input bit gaps, input bit stalls);
    feed(pat, gaps, NELEM);
    drain(stalls);
    check_table(pat);
  endtask

  task automatic wait_init(input string nm);
    int lo = 0;
    int mv = 0;
    while (!bus.s_ready && lo < 2000) begin
      if (bus.m_valid) mv++;
      lo++;
      @(negedge clk);
    end
    chk({nm, "_init_cycles"}, lo, NPIX);
    chk({nm, "_no_output"}, mv, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready",    int'(bus.s_ready),    0);
    chk("rst_m_valid",    int'(bus.m_valid),    0);
    chk("rst_m_data",     int'(bus.m_data),     0);
    chk("rst_m_last",     int'(bus.m_last),     0);
    chk("rst_frame_done", int'(bus.frame_done), 0);
  endtask

  initial begin
    int sum;
    int diffs;
    int fd0;

    vecs = '{
      '{0,  0,  0,    1, "ones_0_0"},
      '{0,  0,  1,    2, "ones_0_1"},
      '{0,  1,  1,    4, "ones_1_1"},
      '{0,  2,  2,    9, "ones_2_2"},
      '{0, 13, 13,    9, "ones_13_13"},
      '{0, 27,  0,    1, "ones_27_0"},
      '{0, 27, 27,    1, "ones_27_27"},
      '{0,  1,  0,    2, "ones_1_0"},
      '{1,  5,  5, 2295, "max_5_5"},
      '{1,  0, 27,  255, "max_0_27"},
      '{1,  0,  0,  255, "max_0_0"},
      '{2,  0,  0,    0, "eidx_0_0"},
      '{2,  0, 27,    2, "eidx_0_27"},
      '{2, 27,  0,    6, "eidx_27_0"},
      '{2, 27, 27,    8, "eidx_27_27"},
      '{2,  0,  1,    1, "eidx_0_1"},
      '{2,  1,  1,    8, "eidx_1_1"},
      '{3,  2,  2,   18, "twos_2_2"},
      '{3,  0,  0,    2, "twos_0_0"}
    };

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    wait_init("boot");

    // All-ones: coverage counts, total, m_last and frame_done handled in drain
    frame(0, 1'b0, 1'b0);
    sum = 0;
    foreach (got[i]) sum += got[i];
    chk("ones_sum", sum, NELEM);

    frame(1, 1'b0, 1'b0);

    frame(2, 1'b0, 1'b0);
    foreach (got[i]) ref_map[i] = got[i];

    // Same data with input gaps and output stalls must give the same map
    frame(2, 1'b1, 1'b1);
    diffs = 0;
    foreach (got[i]) if (got[i] != ref_map[i]) diffs++;
    chk("stall_vs_nostall_diffs", diffs, 0);

    // Back-to-back frames with no INIT between
    fd0 = fd_cnt;
    frame(0, 1'b0, 1'b0);
    frame(3, 1'b0, 1'b0);
    chk("b2b_frame_done_pulses", fd_cnt - fd0, 2);

    // Abort mid-accumulation with a reset; partial sums must not survive
    feed(1, 1'b0, 3000);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("abort");
    frame(0, 1'b0, 1'b0);
    sum = 0;
    foreach (got[i]) sum += got[i];
    chk("abort_ones_sum", sum, NELEM);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/col2im_accum.md
# col2im_accum

Streaming column-to-image reassembler for the CNN accelerator: the inverse of the 3x3 im2col unpacking. It accepts the 3x3 patch column stream in im2col order (26x26 windows over a 28x28 map, 9 elements each) and scatter-adds every element into its source pixel of a 28x28 accumulator map. Once the whole frame has been accumulated, it streams the map out in raster order. It is used on the gradient/overlap-add path and for round-trip checking of the im2col unit.

## Interface
- IMG_W, 28: square image width/height
- K, 3: square kernel size; window grid is OW = IMG_W-K+1 (26)
- DW, 8: input element width, unsigned
- AW, 12: accumulator/output width, unsigned; must satisfy 2^AW > K*K*(2^DW-1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input element valid
- s_ready  out  1  input element accepted when s_valid && s_ready
- s_data  in  DW  patch element
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts when m_valid && m_ready
- m_data  out  AW  accumulated pixel value
- m_last  out  1  high with pixel IMG_W*IMG_W-1
- frame_done  out  1  one-cycle pulse after the last output handshake

## Operation
- Storage: IMG_W*IMG_W registers of AW bits (acc), no reset on the array.
- Input order: window index w = k*OW+l (k row, l col, l fastest); element index e = m*K+n (n fastest). Element (w,e) adds to acc[(k+m)*IMG_W + (l+n)].
- Counters: n, m in 0..K-1, l, k in 0..OW-1, pix in 0..IMG_W*IMG_W-1; each wraps to 0 when it rolls over.
- FSM states:
  - INIT: writes acc[pix]=0 and increments pix each cycle. After pix = IMG_W*IMG_W-1 it goes to ACCUM with pix=0.
  - ACCUM: s_ready=1. Each accepted element does a same-cycle read-modify-write, acc[idx] <= acc[idx] + zero-extended s_data, and advances n→m→l→k. Acceptance of the final element (k=l=OW-1, m=n=K-1) moves the FSM to DRAIN.
  - DRAIN: m_valid=1, m_data=acc[pix], m_last=(pix==IMG_W*IMG_W-1). On handshake, acc[pix] <= 0 and pix increments. The last handshake returns the FSM to ACCUM with pix=0 and pulses frame_done.
- Because DRAIN zeroes each pixel as it goes, back-to-back frames need no INIT pass.
- Arithmetic is an unsigned AW-bit add. The parameter constraint guarantees no overflow, so no saturation logic is required.
- s_valid outside ACCUM is ignored: not accepted and no state change.
- m_ready outside DRAIN is ignored.

## Timing
- Reset (rst_n low, asynchronous): state=INIT and all counters=0. Outputs: s_ready=0, m_valid=0, m_data=0, m_last=0, frame_done=0.
- The first ACCUM cycle, where s_ready=1, is the cycle after the IMG_W*IMG_W-th INIT cycle following rst_n deassertion: cycle 784 with defaults.
- Input throughput is 1 element/cycle; a full frame is 6084 accepted elements.
- s_ready drops the cycle after the final element is accepted, and m_valid rises in the same cycle.
- m_data/m_last are combinational from acc[pix] and the state. They hold stable while m_valid && !m_ready.
- Output throughput is 1 pixel/cycle; a full frame is 784 handshakes.
- frame_done is high for exactly the cycle after the last output handshake, coincident with s_ready=1.
- Reset asserted mid-ACCUM or mid-DRAIN aborts the frame. INIT reruns and clears partial sums, and no output of the aborted frame appears afterwards.
- In ACCUM, a handshake writes the updated value one cycle after acceptance. Consecutive elements hitting the same pixel cannot occur: the index always changes element to element.

## Test plan
- All-ones frame (6084 × s_data=1), m_ready=1 → m_data matches coverage counts: pix(0,0)=1, (0,1)=2, (1,1)=4, (2,2)=9, (13,13)=9, (27,0)=1, (27,27)=1. The sum over all pixels is 6084, and m_last is high only on the 784th pixel.
- All-255 frame → interior pixel (5,5)=2295 and corner (0,27)=255; no wrap.
- s_data = e (element index 0..8) → (0,0)=0, (0,27)=2, (27,0)=6, (27,27)=8, (0,1)=0+1=1.
- Random s_valid gaps plus random m_ready stalls (50%) → results identical to the no-stall run, and m_data holds stable during stalls.
- Two back-to-back frames (all-ones, then all-twos) → the second frame's (2,2)=18, with no carry-over; frame_done pulses exactly twice.
- rst_n pulsed low after 3000 elements → s_ready=0 for 784 cycles. A subsequent full all-ones frame yields exactly the all-ones counts.
